// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  mem_arbiter_if
//  Fetch, load/store and memory-side request/response bundle for mem_arbiter.
//  Revision: 1.0
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  i_req_valid;
   logic                  i_req_ready;
   logic [ADDR_WIDTH-1:0] i_req_addr;
   logic                  i_resp_valid;
   logic [DATA_WIDTH-1:0] i_resp_data;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic                  d_req_we;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic [STRB_WIDTH-1:0] d_req_strobe;
   logic                  d_resp_valid;
   logic [DATA_WIDTH-1:0] d_resp_data;

   logic                  m_req_valid;
   logic                  m_req_ready;
   logic [ADDR_WIDTH-1:0] m_req_addr;
   logic                  m_req_we;
   logic [DATA_WIDTH-1:0] m_req_wdata;
   logic [STRB_WIDTH-1:0] m_req_strobe;
   logic                  m_resp_valid;
   logic [DATA_WIDTH-1:0] m_resp_data;

   // Arbiter view
   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_resp_valid, i_resp_data,
      input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_strobe,
      output d_req_ready, d_resp_valid, d_resp_data,
      output m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_strobe,
      input  m_req_ready, m_resp_valid, m_resp_data
   );

   // Requesters and memory view
   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_resp_valid, i_resp_data,
      output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_strobe,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_strobe,
      output m_req_ready, m_resp_valid, m_resp_data
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_arbiter
//  Round-robin sharing of one memory port between fetch and load/store, with
//  a single outstanding transaction.
//  Revision: 1.0
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        rst,
   mem_arbiter_if.slave     bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q,        state_d;
   logic                  last_grant_q,   last_grant_d;
   logic                  owner_q,        owner_d;
   logic                  m_valid_q,      m_valid_d;
   logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
   logic                  we_q,           we_d;
   logic [DATA_WIDTH-1:0] wdata_q,        wdata_d;
   logic [STRB_WIDTH-1:0] strobe_q,       strobe_d;
   logic                  i_resp_valid_q, i_resp_valid_d;
   logic [DATA_WIDTH-1:0] i_resp_data_q,  i_resp_data_d;
   logic                  d_resp_valid_q, d_resp_valid_d;
   logic [DATA_WIDTH-1:0] d_resp_data_q,  d_resp_data_d;

   logic w_idle;
   logic w_grant_data;
   logic w_handshake;

   // Data wins when it is alone, or on a tie when fetch won last time
   assign w_idle       = (state_q == IDLE);
   assign w_grant_data = bus.d_req_valid && (!bus.i_req_valid || !last_grant_q);
   assign w_handshake  = w_idle && (bus.i_req_valid || bus.d_req_valid);

   assign bus.i_req_ready = w_idle && bus.i_req_valid && !w_grant_data;
   assign bus.d_req_ready = w_idle && w_grant_data;

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      owner_d        = owner_q;
      m_valid_d      = m_valid_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      strobe_d       = strobe_q;
      i_resp_valid_d = 1'b0;
      i_resp_data_d  = i_resp_data_q;
      d_resp_valid_d = 1'b0;
      d_resp_data_d  = d_resp_data_q;

      case (state_q)
         IDLE: begin
            if (w_handshake) begin
               addr_d       = w_grant_data ? bus.d_req_addr   : bus.i_req_addr;
               we_d         = w_grant_data & bus.d_req_we;
               wdata_d      = w_grant_data ? bus.d_req_wdata  : '0;
               strobe_d     = w_grant_data ? bus.d_req_strobe : '0;
               owner_d      = w_grant_data;
               last_grant_d = w_grant_data;
               m_valid_d    = 1'b1;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (bus.m_req_ready) begin
               m_valid_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (bus.m_resp_valid) begin
               if (owner_q) begin
                  d_resp_data_d  = bus.m_resp_data;
                  d_resp_valid_d = 1'b1;
               end else begin
                  i_resp_data_d  = bus.m_resp_data;
                  i_resp_valid_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         last_grant_q   <= 1'b1;
         owner_q        <= 1'b0;
         m_valid_q      <= 1'b0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         strobe_q       <= '0;
         i_resp_valid_q <= 1'b0;
         i_resp_data_q  <= '0;
         d_resp_valid_q <= 1'b0;
         d_resp_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         owner_q        <= owner_d;
         m_valid_q      <= m_valid_d;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         strobe_q       <= strobe_d;
         i_resp_valid_q <= i_resp_valid_d;
         i_resp_data_q  <= i_resp_data_d;
         d_resp_valid_q <= d_resp_valid_d;
         d_resp_data_q  <= d_resp_data_d;
      end
   end

   assign bus.m_req_valid  = m_valid_q;
   assign bus.m_req_addr   = addr_q;
   assign bus.m_req_we     = we_q;
   assign bus.m_req_wdata  = wdata_q;
   assign bus.m_req_strobe = strobe_q;
   assign bus.i_resp_valid = i_resp_valid_q;
   assign bus.i_resp_data  = i_resp_data_q;
   assign bus.d_resp_valid = d_resp_valid_q;
   assign bus.d_resp_data  = d_resp_data_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mem_arbiter
//  Directed scenarios plus randomized traffic against a transaction-level model.
//  Revision: 1.0
// ============================================================================
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;
   int   last_wait  = 0;

   // Model state: round-robin memory and last data delivered per requester
   bit            lg_model;
   logic [DW-1:0] exp_i_data;
   logic [DW-1:0] exp_d_data;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, bus.m_req_valid, 0);
      chk({tag, "_m_addr"},  bus.m_req_addr, 0);
      chk({tag, "_m_we"},    bus.m_req_we, 0);
      chk({tag, "_m_wdata"}, bus.m_req_wdata, 0);
      chk({tag, "_m_strb"},  bus.m_req_strobe, 0);
      chk({tag, "_i_rv"},    bus.i_resp_valid, 0);
      chk({tag, "_d_rv"},    bus.d_resp_valid, 0);
      chk({tag, "_i_rd"},    bus.i_resp_data, 0);
      chk({tag, "_d_rd"},    bus.d_resp_data, 0);
   endtask

   // One full transaction: wait for the memory request, check it, stall,
   // respond, then check that exactly the owner sees the response pulse.
   task automatic do_txn(input bit ed, input logic [AW-1:0] ea, input bit ewe,
                         input logic [DW-1:0] ewd, input logic [SW-1:0] es,
                         input int sreq, input int sresp,
                         input logic [DW-1:0] rdata, input bit spur);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (bus.m_req_valid !== 1'b1 && k < 40);
      last_wait = k;
      chk("m_req_valid", bus.m_req_valid, 1);
      chk("m_req_addr",  bus.m_req_addr, ea);
      chk("m_req_we",    bus.m_req_we, ewe);
      chk("m_req_wdata", bus.m_req_wdata, ewd);
      chk("m_req_strobe", bus.m_req_strobe, es);
      chk("i_rv_in_req", bus.i_resp_valid, 0);
      chk("d_rv_in_req", bus.d_resp_valid, 0);
      if (ed) bus.d_req_valid = 1'b0;
      else    bus.i_req_valid = 1'b0;
      for (int j = 0; j < sreq; j++) begin
         bus.m_resp_valid = spur;
         bus.m_resp_data  = 32'hBAD0_0000 | j;
         cyc();
         chk("stall_m_valid", bus.m_req_valid, 1);
         chk("stall_m_addr",  bus.m_req_addr, ea);
         chk("stall_m_wdata", bus.m_req_wdata, ewd);
         chk("stall_i_ready", bus.i_req_ready, 0);
         chk("stall_d_ready", bus.d_req_ready, 0);
         chk("stall_rv", {bus.i_resp_valid, bus.d_resp_valid}, 0);
      end
      bus.m_req_ready  = 1'b1;
      bus.m_resp_valid = spur;
      bus.m_resp_data  = 32'hBAD1_0000;
      cyc();
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b0;
      chk("resp_m_valid", bus.m_req_valid, 0);
      for (int j = 0; j < sresp; j++) begin
         cyc();
         chk("wait_rv", {bus.i_resp_valid, bus.d_resp_valid}, 0);
         chk("wait_ready", {bus.i_req_ready, bus.d_req_ready}, 0);
      end
      chk("pre_rv", {bus.i_resp_valid, bus.d_resp_valid}, 0);
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = rdata;
      cyc();
      bus.m_resp_valid = 1'b0;
      if (ed) exp_d_data = rdata;
      else    exp_i_data = rdata;
      lg_model = ed;
      chk("i_resp_valid", bus.i_resp_valid, !ed);
      chk("d_resp_valid", bus.d_resp_valid, ed);
      chk("i_resp_data",  bus.i_resp_data, exp_i_data);
      chk("d_resp_data",  bus.d_resp_data, exp_d_data);
   endtask

   initial begin
      bit            ip, dp, ed, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic [SW-1:0] es;

      rst = 1'b0;
      bus.i_req_valid = 0; bus.i_req_addr = '0;
      bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_we = 0;
      bus.d_req_wdata = '0; bus.d_req_strobe = '0;
      bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_resp_data = '0;
      lg_model = 1'b1; exp_i_data = '0; exp_d_data = '0;
      repeat (3) cyc();
      chk_reset_outputs("reset");
      chk("reset_ready", {bus.i_req_ready, bus.d_req_ready}, 0);
      rst = 1'b1;

      // Single fetch
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h100;
      #1;
      chk("fetch_i_ready", bus.i_req_ready, 1);
      chk("fetch_d_ready", bus.d_req_ready, 0);
      do_txn(0, 32'h100, 0, '0, '0, 0, 0, 32'h0050_0093, 0);
      chk("fetch_latency", last_wait, 1);

      // Simultaneous after reset: fetch first, then the store back-to-back
      rst = 1'b0; cyc(); rst = 1'b1;
      lg_model = 1'b1; exp_i_data = '0; exp_d_data = '0;
      bus.i_req_valid = 1; bus.i_req_addr = 32'h104;
      bus.d_req_valid = 1; bus.d_req_addr = 32'h200; bus.d_req_we = 1;
      bus.d_req_wdata = 32'hDEAD_BEEF; bus.d_req_strobe = 4'hF;
      #1;
      chk("tie_i_ready", bus.i_req_ready, 1);
      chk("tie_d_ready", bus.d_req_ready, 0);
      do_txn(0, 32'h104, 0, '0, '0, 0, 0, 32'h1111_1111, 0);
      do_txn(1, 32'h200, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0);
      chk("b2b_latency", last_wait, 1);

      // Stalled load
      bus.d_req_valid = 1; bus.d_req_addr = 32'h300; bus.d_req_we = 0;
      bus.d_req_wdata = '0; bus.d_req_strobe = '0;
      bus.i_req_valid = 1; bus.i_req_addr = 32'h108;
      bus.i_req_valid = 0;
      do_txn(1, 32'h300, 0, '0, '0, 5, 7, 32'h1234_5678, 0);

      // Spurious response in IDLE, then during REQ
      bus.m_resp_valid = 1; bus.m_resp_data = 32'hFFFF_0000;
      cyc();
      bus.m_resp_valid = 0;
      cyc();
      chk("spur_idle_rv", {bus.i_resp_valid, bus.d_resp_valid}, 0);
      chk("spur_idle_m_valid", bus.m_req_valid, 0);
      chk("spur_idle_d_rd", bus.d_resp_data, exp_d_data);
      bus.i_req_valid = 1; bus.i_req_addr = 32'h10C;
      do_txn(0, 32'h10C, 0, '0, '0, 2, 1, 32'hA5A5_0001, 1);

      // Reset while waiting for the memory response
      bus.i_req_valid = 1; bus.i_req_addr = 32'h400;
      cyc();
      bus.i_req_valid = 0; bus.m_req_ready = 1;
      cyc();
      bus.m_req_ready = 0;
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      cyc();
      rst = 1'b1;
      lg_model = 1'b1; exp_i_data = '0; exp_d_data = '0;
      bus.m_resp_valid = 1; bus.m_resp_data = 32'hBBBB_BBBB;
      cyc();
      bus.m_resp_valid = 0;
      chk("midrst_rv1", {bus.i_resp_valid, bus.d_resp_valid}, 0);
      cyc();
      chk("midrst_rv2", {bus.i_resp_valid, bus.d_resp_valid}, 0);
      bus.d_req_valid = 1; bus.d_req_addr = 32'h500; bus.d_req_we = 1;
      bus.d_req_wdata = 32'h0BAD_F00D; bus.d_req_strobe = 4'h3;
      do_txn(1, 32'h500, 1, 32'h0BAD_F00D, 4'h3, 1, 0, 32'h7777_0000, 0);

      // Randomized traffic; requesters hold valid until granted
      ip = 0; dp = 0;
      for (int t = 0; t < 40; t++) begin
         if (!ip && !dp) begin
            int r = $urandom_range(1, 3);
            ip = r[0];
            dp = r[1];
            if (ip) begin bus.i_req_valid = 1; bus.i_req_addr = $urandom & 32'hFFFF_FFFC; end
            if (dp) begin
               bus.d_req_valid = 1; bus.d_req_addr = $urandom; bus.d_req_we = $urandom_range(0, 1);
               bus.d_req_wdata = $urandom; bus.d_req_strobe = $urandom_range(0, 15);
            end
         end
         ed  = dp && (!ip || !lg_model);
         ea  = ed ? bus.d_req_addr : bus.i_req_addr;
         ewe = ed && bus.d_req_we;
         ewd = ed ? bus.d_req_wdata : '0;
         es  = ed ? bus.d_req_strobe : '0;
         do_txn(ed, ea, ewe, ewd, es, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, 1'($urandom_range(0, 1)));
         if (ed) dp = 0; else ip = 0;
         if (!ip && $urandom_range(0, 1) == 1) begin
            ip = 1; bus.i_req_valid = 1; bus.i_req_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!dp && $urandom_range(0, 1) == 1) begin
            dp = 1; bus.d_req_valid = 1; bus.d_req_addr = $urandom; bus.d_req_we = $urandom_range(0, 1);
            bus.d_req_wdata = $urandom; bus.d_req_strobe = $urandom_range(0, 15);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
